counter_mod_updown: RTL and testbench

- Parametrised modulo-M up/down counter with count enable, synchronous clear and parallel load.
- Selectable wrap or saturate mode.
- Carry-style terminal-count strobe (tick) for cascading stages and generating clock-enable rates.
- Min/max flags.
- Generalises the free-running N-bit counter used across the lab designs (clock dividers, digit scanners, stopwatch stages).

---
 rtl/counter_mod_updown.sv | 76 +++++++
 tb/tb_counter_mod_updown.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_updown.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod_updown
// Brief    : Modulo-MOD up/down counter with clear, clamped load, wrap or
//            saturate mode, terminal-count tick and min/max flags.
// Revision : 1.0 - initial release
// ============================================================================
module counter_mod_updown #(
    parameter int     BITS = 4,
    parameter longint MOD  = 16,
    parameter int     MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            up,
    input  logic            clr,
    input  logic            load,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] q,
    output logic            tick,
    output logic            at_max,
    output logic            at_min
);

    // Built one bit wider so MOD == 2**BITS does not overflow before truncation.
    localparam logic [BITS:0]   c_max_w  = (BITS+1)'(MOD - 1);
    localparam logic [BITS:0]   c_pre_w  = (BITS+1)'(MOD - 2);
    localparam logic [BITS-1:0] c_max    = c_max_w[BITS-1:0];
    localparam logic [BITS-1:0] c_premax = c_pre_w[BITS-1:0];
    localparam logic [BITS-1:0] c_one    = BITS'(1);
    localparam logic            c_sat    = (MODE == 1);

    logic [BITS-1:0] r_q;
    logic [BITS-1:0] w_q_next;
    logic            w_step;

    always_comb begin
        w_q_next = r_q;
        if (clr) begin
            w_q_next = '0;
        end else if (load) begin
            w_q_next = (din > c_max) ? c_max : din;
        end else if (en) begin
            if (up) begin
                if (r_q == c_max) w_q_next = c_sat ? r_q : '0;
                else              w_q_next = r_q + c_one;
            end else begin
                if (r_q == '0)    w_q_next = c_sat ? r_q : c_max;
                else              w_q_next = r_q - c_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= w_q_next;
    end

    assign w_step = en & ~clr & ~load;

    generate
        if (MODE == 1) begin : g_tick_sat
            // Fires on the step that lands on the terminal value, never while held.
            assign tick = w_step & (up ? (r_q == c_premax) : (r_q == c_one));
        end else begin : g_tick_wrap
            assign tick = w_step & (up ? (r_q == c_max) : (r_q == '0));
        end
    endgenerate

    assign q      = r_q;
    assign at_max = (r_q == c_max);
    assign at_min = (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_updown.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_mod_updown
// Brief    : Scoreboard bench for four counter configurations plus a two-stage
//            decade cascade, driven by directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_mod_updown;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] din = '0;

    always #5 clk = ~clk;

    // Instances 0..3: {MOD10 wrap, MOD10 sat, MOD16 wrap, MOD2 sat (1 bit)}
    logic [3:0] aq [4];
    logic       at [4];
    logic       amx[4];
    logic       amn[4];
    logic       d_q, d_t, d_mx, d_mn;

    counter_mod_updown #(.BITS(4), .MOD(10), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .q(aq[0]), .tick(at[0]), .at_max(amx[0]), .at_min(amn[0]));
    counter_mod_updown #(.BITS(4), .MOD(10), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .q(aq[1]), .tick(at[1]), .at_max(amx[1]), .at_min(amn[1]));
    counter_mod_updown #(.BITS(4), .MOD(16), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .din(din),
        .q(aq[2]), .tick(at[2]), .at_max(amx[2]), .at_min(amn[2]));
    counter_mod_updown #(.BITS(1), .MOD(2), .MODE(1)) u3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .din(din[0]),
        .q(d_q), .tick(d_t), .at_max(d_mx), .at_min(d_mn));

    assign aq[3]  = {3'b000, d_q};
    assign at[3]  = d_t;
    assign amx[3] = d_mx;
    assign amn[3] = d_mn;

    // Decade cascade: stage 2 steps on stage 1's tick.
    logic [3:0] c1q, c2q;
    logic       c1t, c2t, c1mx, c1mn, c2mx, c2mn;

    counter_mod_updown #(.BITS(4), .MOD(10), .MODE(0)) uc1 (
        .clk(clk), .rst(rst), .en(en), .up(1'b1), .clr(1'b0), .load(1'b0), .din(4'd0),
        .q(c1q), .tick(c1t), .at_max(c1mx), .at_min(c1mn));
    counter_mod_updown #(.BITS(4), .MOD(10), .MODE(0)) uc2 (
        .clk(clk), .rst(rst), .en(c1t), .up(1'b1), .clr(1'b0), .load(1'b0), .din(4'd0),
        .q(c2q), .tick(c2t), .at_max(c2mx), .at_min(c2mn));

    typedef struct packed {
        logic [3:0][3:0] q;
        logic [3:0]      t;
        logic [3:0]      mx;
        logic [3:0]      mn;
        logic [3:0]      c1;
        logic [3:0]      c2;
        logic [1:0]      ct;
        logic [3:0]      cflags;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: plain counts, one per instance, plus cascade total.
    int   mq[4];
    int   modv[4] = '{10, 10, 16, 2};
    bit   satv[4] = '{0, 1, 0, 1};
    int   cn = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, req);
        end
    endtask

    function automatic int stepped(input int i, input int v, input bit dir);
        int m = modv[i];
        if (dir) return satv[i] ? ((v + 1 > m - 1) ? m - 1 : v + 1) : (v + 1) % m;
        else     return satv[i] ? ((v - 1 < 0) ? 0 : v - 1) : (v - 1 + m) % m;
    endfunction

    task automatic cyc(input bit e, input bit u, input bit c, input bit l, input logic [3:0] d, input bit r);
        exp_t x;
        bit   step;
        int   dv;
        int   nxt;
        @(negedge clk);
        en = e; up = u; clr = c; load = l; din = d; rst = r;
        step = e && !c && !l;
        if (r) begin
            foreach (mq[i]) mq[i] = 0;
            cn = 0;
        end
        for (int i = 0; i < 4; i++) begin
            x.q[i]  = 4'(mq[i]);
            x.mx[i] = (mq[i] == modv[i] - 1);
            x.mn[i] = (mq[i] == 0);
            nxt     = stepped(i, mq[i], u);
            if (satv[i]) begin
                x.t[i] = step && (nxt == (u ? modv[i] - 1 : 0)) && (nxt != mq[i]);
            end else begin
                x.t[i] = step && (u ? (mq[i] == modv[i] - 1) : (mq[i] == 0));
            end
        end
        x.c1     = 4'(cn % 10);
        x.c2     = 4'((cn / 10) % 10);
        x.ct[0]  = e && (cn % 10 == 9);
        x.ct[1]  = e && (cn % 100 == 99);
        x.cflags = {cn % 10 == 9, cn % 10 == 0, (cn / 10) % 10 == 9, (cn / 10) % 10 == 0};
        sb.push_back(x);
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                dv = (i == 3) ? int'(d[0]) : int'(d);
                if (c)      mq[i] = 0;
                else if (l) mq[i] = (dv > modv[i] - 1) ? modv[i] - 1 : dv;
                else if (e) mq[i] = stepped(i, mq[i], u);
            end
            if (e) cn++;
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk("q",      i, 32'(aq[i]),  32'(x.q[i]));
                    chk("tick",   i, 32'(at[i]),  32'(x.t[i]));
                    chk("at_max", i, 32'(amx[i]), 32'(x.mx[i]));
                    chk("at_min", i, 32'(amn[i]), 32'(x.mn[i]));
                end
                chk("casc_q1",    0, 32'(c1q), 32'(x.c1));
                chk("casc_q2",    0, 32'(c2q), 32'(x.c2));
                chk("casc_tick",  0, 32'({c2t, c1t}), 32'(x.ct));
                chk("casc_flags", 0, 32'({c1mx, c1mn, c2mx, c2mn}), 32'(x.cflags));
            end
        end
    end

    initial begin : driver
        foreach (mq[i]) mq[i] = 0;
        repeat (3) cyc(0, 1, 0, 0, 4'd0, 1);
        repeat (22) cyc(1, 1, 0, 0, 4'd0, 0);
        repeat (12) cyc(1, 0, 0, 0, 4'd0, 0);
        cyc(0, 1, 0, 1, 4'd5, 0);
        repeat (2) cyc(1, 0, 0, 0, 4'd0, 0);
        repeat (3) cyc(1, 1, 0, 0, 4'd0, 0);
        cyc(0, 1, 0, 1, 4'd12, 0);
        cyc(1, 1, 0, 1, 4'd3, 0);
        cyc(1, 1, 1, 1, 4'd7, 0);
        repeat (5) cyc(0, 1, 0, 0, 4'd0, 0);
        repeat (6) cyc(1, 1, 0, 0, 4'd0, 0);
        cyc(1, 1, 0, 0, 4'd0, 1);
        repeat (105) cyc(1, 1, 0, 0, 4'd0, 0);
        repeat (2000) begin
            cyc($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(15, 0) == 0,
                $urandom_range(9, 0) == 0, 4'($urandom), $urandom_range(99, 0) == 0);
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
